// File: rtl/modn_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : modn_updown_counter
// Description : Up/down counter modulo a runtime-programmable N, with load,
//               terminal count, wrap pulse and saturating wrap counter.
// Revision    : 1.0 - initial release
// ============================================================================
module modn_updown_counter #(
    parameter int WIDTH     = 3,
    parameter int N_DEFAULT = 8,
    parameter int WCNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              up_down,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              mod_set,
    input  logic [WIDTH:0]    mod_in,
    output logic [WIDTH-1:0]  dataout,
    output logic              tc,
    output logic              wrap,
    output logic [WCNT_W-1:0] wrap_cnt,
    output logic              mod_err
);

    localparam logic [WIDTH:0]    c_n_max   = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]    c_n_min   = (WIDTH+1)'(2);
    localparam logic [WIDTH:0]    c_n_reset = (WIDTH+1)'(N_DEFAULT);
    localparam logic [WCNT_W-1:0] c_wcnt_max = {WCNT_W{1'b1}};

    generate
        if (N_DEFAULT < 2 || N_DEFAULT > (1 << WIDTH)) begin : g_bad_n_default
            $error("modn_updown_counter: N_DEFAULT out of range 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0]  r_count;
    logic [WIDTH:0]    r_n;
    logic              r_wrap;
    logic [WCNT_W-1:0] r_wrap_cnt;
    logic              r_mod_err;

    logic              w_mod_legal;
    logic [WIDTH:0]    w_n_next;
    logic [WIDTH:0]    w_n_next_minus1;
    logic [WIDTH:0]    w_n_minus1;
    logic [WIDTH:0]    w_count_ext;
    logic [WIDTH:0]    w_load_ext;
    logic              w_load_ok;
    logic [WIDTH-1:0]  w_count_d;
    logic              w_wrap_d;
    logic              w_err_d;

    always_comb begin
        w_mod_legal     = (mod_in >= c_n_min) && (mod_in <= c_n_max);
        // A legal mod_set in the same cycle governs the load range check.
        w_n_next        = (mod_set && w_mod_legal) ? mod_in : r_n;
        w_n_next_minus1 = w_n_next - (WIDTH+1)'(1);
        w_n_minus1      = r_n - (WIDTH+1)'(1);
        w_count_ext     = {1'b0, r_count};
        w_load_ext      = {1'b0, load_value};
        w_load_ok       = (w_load_ext <= w_n_next_minus1);
    end

    always_comb begin
        w_count_d = r_count;
        w_wrap_d  = 1'b0;
        w_err_d   = mod_set && !w_mod_legal;
        if (load) begin
            if (w_load_ok) begin
                w_count_d = load_value;
            end else begin
                w_count_d = w_n_next_minus1[WIDTH-1:0];
                w_err_d   = 1'b1;
            end
        end else if (enable) begin
            if (up_down) begin
                // Covers both the natural top and a count left stale above N-1.
                if (w_count_ext >= w_n_minus1) begin
                    w_count_d = '0;
                    w_wrap_d  = 1'b1;
                end else begin
                    w_count_d = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_count_d = w_n_minus1[WIDTH-1:0];
                    w_wrap_d  = 1'b1;
                end else if (w_count_ext >= r_n) begin
                    w_count_d = w_n_minus1[WIDTH-1:0];
                end else begin
                    w_count_d = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_n        <= c_n_reset;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= '0;
            r_mod_err  <= 1'b0;
        end else begin
            r_count   <= w_count_d;
            r_n       <= w_n_next;
            r_wrap    <= w_wrap_d;
            r_mod_err <= r_mod_err | w_err_d;
            if (w_wrap_d && (r_wrap_cnt != c_wcnt_max)) begin
                r_wrap_cnt <= r_wrap_cnt + WCNT_W'(1);
            end
        end
    end

    assign dataout  = r_count;
    assign tc       = up_down ? (w_count_ext == w_n_minus1) : (r_count == '0);
    assign wrap     = r_wrap;
    assign wrap_cnt = r_wrap_cnt;
    assign mod_err  = r_mod_err;

endmodule
`default_nettype wire

// File: tb/tb_modn_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_modn_updown_counter
// Description : Directed self-checking bench for modn_updown_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modn_updown_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [2:0] load_value;
    logic       mod_set;
    logic [3:0] mod_in;
    logic [2:0] dataout;
    logic       tc;
    logic       wrap;
    logic [7:0] wrap_cnt;
    logic       mod_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    modn_updown_counter #(.WIDTH(3), .N_DEFAULT(8), .WCNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .mod_set    (mod_set),
        .mod_in     (mod_in),
        .dataout    (dataout),
        .tc         (tc),
        .wrap       (wrap),
        .wrap_cnt   (wrap_cnt),
        .mod_err    (mod_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; enable = 1'b0; up_down = 1'b0; load = 1'b0;
        load_value = '0; mod_set = 1'b0; mod_in = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++;
        if ({dataout, wrap, wrap_cnt, mod_err} !== {3'd0, 1'b0, 8'd0, 1'b0})
            $display("FAIL reset_state: got d=%0d w=%0b wc=%0d e=%0b want 0/0/0/0",
                     dataout, wrap, wrap_cnt, mod_err);
        else pass_cnt++;
    endtask

    task automatic test_count_up();
        int exp;
        apply_reset();
        up_down = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = i % 8;
            total_cnt++;
            if (dataout !== 3'(exp)) $display("FAIL up_count step %0d: got %0d want %0d", i, dataout, exp);
            else pass_cnt++;
            total_cnt++;
            if (wrap !== (exp == 0)) $display("FAIL up_wrap step %0d: got %0b want %0b", i, wrap, exp == 0);
            else pass_cnt++;
            total_cnt++;
            if (tc !== (exp == 7)) $display("FAIL up_tc step %0d: got %0b want %0b", i, tc, exp == 7);
            else pass_cnt++;
        end
        total_cnt++;
        if (wrap_cnt !== 8'd1) $display("FAIL up_wrap_cnt: got %0d want 1", wrap_cnt);
        else pass_cnt++;
        enable = 1'b0;
        tick();
        total_cnt++;
        if ({dataout, wrap, wrap_cnt} !== {3'd0, 1'b0, 8'd1})
            $display("FAIL up_hold: got d=%0d w=%0b wc=%0d want 0/0/1", dataout, wrap, wrap_cnt);
        else pass_cnt++;
    endtask

    task automatic test_count_down();
        int exp;
        apply_reset();
        total_cnt++;
        if (tc !== 1'b1) $display("FAIL down_tc_at_zero: got %0b want 1", tc);
        else pass_cnt++;
        enable = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            tick();
            exp = (15 - i) % 8;
            total_cnt++;
            if (dataout !== 3'(exp)) $display("FAIL down_count step %0d: got %0d want %0d", i, dataout, exp);
            else pass_cnt++;
            total_cnt++;
            if (wrap !== (exp == 7)) $display("FAIL down_wrap step %0d: got %0b want %0b", i, wrap, exp == 7);
            else pass_cnt++;
            total_cnt++;
            if (tc !== (exp == 0)) $display("FAIL down_tc step %0d: got %0b want %0b", i, tc, exp == 0);
            else pass_cnt++;
        end
        total_cnt++;
        if (wrap_cnt !== 8'd2) $display("FAIL down_wrap_cnt: got %0d want 2", wrap_cnt);
        else pass_cnt++;
    endtask

    task automatic test_load();
        apply_reset();
        up_down = 1'b1; enable = 1'b1; load = 1'b1; load_value = 3'd5;
        tick();
        load = 1'b0;
        total_cnt++;
        if ({dataout, wrap} !== {3'd5, 1'b0}) $display("FAIL load_value: got d=%0d w=%0b want 5/0", dataout, wrap);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (dataout !== 3'd6) $display("FAIL load_next6: got %0d want 6", dataout);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (dataout !== 3'd7) $display("FAIL load_next7: got %0d want 7", dataout);
        else pass_cnt++;
        load = 1'b1; load_value = 3'd2;
        tick();
        load = 1'b0;
        total_cnt++;
        if ({dataout, wrap, mod_err} !== {3'd2, 1'b0, 1'b0})
            $display("FAIL load_at_top: got d=%0d w=%0b e=%0b want 2/0/0", dataout, wrap, mod_err);
        else pass_cnt++;
    endtask

    task automatic test_mod_change();
        apply_reset();
        load = 1'b1; load_value = 3'd6;
        tick();
        load = 1'b0; mod_set = 1'b1; mod_in = 4'd5;
        tick();
        mod_set = 1'b0;
        total_cnt++;
        if ({dataout, mod_err} !== {3'd6, 1'b0}) $display("FAIL mod_hold: got d=%0d e=%0b want 6/0", dataout, mod_err);
        else pass_cnt++;
        up_down = 1'b1; enable = 1'b1;
        total_cnt++;
        if (tc !== 1'b0) $display("FAIL mod_stale_tc: got %0b want 0", tc);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({dataout, wrap} !== {3'd0, 1'b1}) $display("FAIL mod_stale_wrap: got d=%0d w=%0b want 0/1", dataout, wrap);
        else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total_cnt++;
            if ({dataout, wrap, tc} !== {3'(i), 1'b0, (i == 4)})
                $display("FAIL mod5_count %0d: got d=%0d w=%0b tc=%0b want %0d/0/%0b", i, dataout, wrap, tc, i, i == 4);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({dataout, wrap, wrap_cnt} !== {3'd0, 1'b1, 8'd2})
            $display("FAIL mod5_wrap: got d=%0d w=%0b wc=%0d want 0/1/2", dataout, wrap, wrap_cnt);
        else pass_cnt++;
        // Stale count above N-1 counting down goes to N-1 without a wrap.
        apply_reset();
        load = 1'b1; load_value = 3'd7;
        tick();
        load = 1'b0; mod_set = 1'b1; mod_in = 4'd5;
        tick();
        mod_set = 1'b0; enable = 1'b1; up_down = 1'b0;
        tick();
        total_cnt++;
        if ({dataout, wrap} !== {3'd4, 1'b0}) $display("FAIL stale_down: got d=%0d w=%0b want 4/0", dataout, wrap);
        else pass_cnt++;
    endtask

    task automatic test_mod_err();
        apply_reset();
        mod_set = 1'b1; mod_in = 4'd1;
        tick();
        total_cnt++;
        if (mod_err !== 1'b1) $display("FAIL mod_err_low: got %0b want 1", mod_err);
        else pass_cnt++;
        mod_in = 4'd9;
        tick();
        mod_set = 1'b0;
        load = 1'b1; load_value = 3'd6;
        tick();
        load = 1'b0; up_down = 1'b1; enable = 1'b1;
        tick();
        total_cnt++;
        if ({dataout, mod_err} !== {3'd7, 1'b1}) $display("FAIL mod_unchanged7: got d=%0d e=%0b want 7/1", dataout, mod_err);
        else pass_cnt++;
        tick();
        enable = 1'b0;
        total_cnt++;
        if ({dataout, wrap} !== {3'd0, 1'b1}) $display("FAIL mod_unchanged_wrap: got d=%0d w=%0b want 0/1", dataout, wrap);
        else pass_cnt++;
        mod_set = 1'b1; mod_in = 4'd8;
        tick();
        mod_set = 1'b0;
        total_cnt++;
        if (mod_err !== 1'b1) $display("FAIL mod_err_sticky: got %0b want 1", mod_err);
        else pass_cnt++;
        // Legal boundaries 2 and 8 leave mod_err clear; out-of-range load sets it.
        apply_reset();
        mod_set = 1'b1; mod_in = 4'd2;
        tick();
        mod_in = 4'd5;
        tick();
        mod_set = 1'b0;
        total_cnt++;
        if (mod_err !== 1'b0) $display("FAIL mod_legal_no_err: got %0b want 0", mod_err);
        else pass_cnt++;
        load = 1'b1; load_value = 3'd7;
        tick();
        load = 1'b0;
        total_cnt++;
        if ({dataout, mod_err} !== {3'd4, 1'b1}) $display("FAIL load_clamp: got d=%0d e=%0b want 4/1", dataout, mod_err);
        else pass_cnt++;
        // Same-cycle legal mod_set sets the range used by the load.
        apply_reset();
        load = 1'b1; load_value = 3'd6; mod_set = 1'b1; mod_in = 4'd5;
        tick();
        load = 1'b0; mod_set = 1'b0;
        total_cnt++;
        if ({dataout, mod_err} !== {3'd4, 1'b1}) $display("FAIL load_same_cycle_mod: got d=%0d e=%0b want 4/1", dataout, mod_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        up_down = 1'b1; enable = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if (dataout !== 3'd3) $display("FAIL mid_pre: got %0d want 3", dataout);
        else pass_cnt++;
        reset = 1'b1; load = 1'b1; load_value = 3'd5; mod_set = 1'b1; mod_in = 4'd1;
        tick();
        reset = 1'b0; load = 1'b0; mod_set = 1'b0;
        total_cnt++;
        if ({dataout, wrap, wrap_cnt, mod_err} !== {3'd0, 1'b0, 8'd0, 1'b0})
            $display("FAIL mid_reset: got d=%0d w=%0b wc=%0d e=%0b want 0/0/0/0", dataout, wrap, wrap_cnt, mod_err);
        else pass_cnt++;
        repeat (4) tick();
        total_cnt++;
        if (dataout !== 3'd4) $display("FAIL mid_modulus_default: got %0d want 4", dataout);
        else pass_cnt++;
    endtask

    task automatic test_wrap_saturation();
        apply_reset();
        mod_set = 1'b1; mod_in = 4'd2;
        tick();
        mod_set = 1'b0; up_down = 1'b1; enable = 1'b1;
        repeat (508) tick();
        total_cnt++;
        if (wrap_cnt !== 8'd254) $display("FAIL sat_254: got %0d want 254", wrap_cnt);
        else pass_cnt++;
        repeat (2) tick();
        total_cnt++;
        if (wrap_cnt !== 8'd255) $display("FAIL sat_255: got %0d want 255", wrap_cnt);
        else pass_cnt++;
        repeat (20) tick();
        total_cnt++;
        if ({wrap_cnt, dataout, wrap} !== {8'd255, 3'd0, 1'b1})
            $display("FAIL sat_hold: got wc=%0d d=%0d w=%0b want 255/0/1", wrap_cnt, dataout, wrap);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up_down = 1'b0; load = 1'b0;
        load_value = '0; mod_set = 1'b0; mod_in = '0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_mod_change();
        test_mod_err();
        test_reset_mid();
        test_wrap_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
